mem_initiator: RTL and testbench
================================

# mem_initiator

CPU-side bus master for the multiplexed AddrData memory bus. It accepts one 4-word read or write request from a local client over a valid/ready handshake. It sequences the address phase and four data beats on AddrData/AddrValid/rw, then returns read data with a one-cycle response pulse. It sits at the opposite end of the bus from the page-decoding memory controller and replaces hand-written testbench bus driving.

## Interface
- RD_SKEW, 1: cycles between the end of the address phase and the first read beat being valid on AddrData; legal range 0–3.
- clk  in  1  clock, shared with the memory controller.
- resetH  in  1  reset; asynchronous, active-high.
- req_valid  in  1  client request present.
- req_ready  out  1  high only in IDLE; the request is accepted on the edge where req_valid && req_ready.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  16  full bus address; page is in [15:12], word offset is in [7:0].
- wr_data  in  64  write words; word k is in [16k+15:16k].
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rd_data  out  64  read words, same packing as wr_data; valid from the rsp_valid cycle until the next read completes.
- busy  out  1  high in every state except IDLE.
- AddrValid  out  1  high only during the address phase.
- rw  out  1  latched req_rw; meaningful while AddrValid is high.
- AddrData  inout  16  bidirectional bus; driven only in ADDR and in write beats, otherwise 'z.

## Operation
- The block captures req_rw, req_addr and wr_data into internal registers on acceptance. Later changes on the request inputs have no effect on that transaction.
- States are IDLE, ADDR, XFER and DONE. A 3-bit beat counter (beat) runs in XFER.
- IDLE → ADDR on acceptance; otherwise the FSM stays in IDLE.
- ADDR lasts one cycle: AddrValid=1, AddrData=latched address, rw=latched rw. Next state is XFER with beat=0.
- Write XFER lasts 4 cycles. In cycle beat=k, AddrData=word k for k=0..3. Exit to DONE after beat=3.
- Read XFER lasts 4+RD_SKEW cycles and AddrData stays tristated throughout. On the rising edge ending cycle beat=RD_SKEW+k, rd_data word k ← AddrData, for k=0..3. Exit to DONE after beat=RD_SKEW+3.
- DONE lasts one cycle. rsp_valid=1, the bus is tristated and AddrValid=0. This cycle is also the bus turnaround. Next state is always IDLE.
- The initiator performs no page check and no address arithmetic. The target increments the low address byte modulo 256; for example, 0x20FE reaches offsets FE, FF, 00, 01.
- Reads to a page with no responding target still complete on schedule, and the captured data is undefined.
- Reset values: state=IDLE, AddrValid=0, rw=1, AddrData='z, rsp_valid=0, busy=0, rd_data=0. Latched request registers reset to 0.
- Reset asserted mid-transaction aborts immediately and asynchronously. No rsp_valid is produced. The bus is released in the same cycle.

## Timing
- Acceptance edge is T0. ADDR occupies cycle T0+1. XFER runs cycles T0+2 … T0+5 for a write, and T0+2 … T0+5+RD_SKEW for a read.
- rsp_valid is high in cycle T0+6 for a write and T0+6+RD_SKEW for a read.
- With req_valid held high, the next acceptance happens at the edge ending the IDLE cycle after DONE. Minimum issue spacing is 7 cycles for writes and 7+RD_SKEW for reads.
- All outputs are registered or decoded from state/beat only. No input-to-output combinational path exists except AddrData being sampled into registers.
- The AddrData drive enable is a registered decode of state, rw and beat. The initiator and target never drive the bus in the same cycle, given the DONE turnaround.

## Structure
- Shared package mem_bus_pkg holds: state typedef (IDLE, ADDR, XFER, DONE), BEATS=4, WORD_W=16, ADDR_W=16, PAGE_SHIFT=12.
- Single module; no sub-module is warranted. The tristate driver is one continuous assign on AddrData.

## Test plan
- **Write beats:** write req_addr=0x2010, words 0xA001/0xA002/0xA003/0xA004 to a PAGE=2 target. Required response: AddrValid=1 for one cycle with AddrData=0x2010 and rw=0, then the four words on consecutive cycles, then rsp_valid at T0+6. Target offsets 0x10–0x13 then hold those values.
- **Read-back:** read 0x2010 with RD_SKEW matched to the target. Required response: AddrData tristated from T0+2, rsp_valid at T0+6+RD_SKEW, rd_data=0xA004_A003_A002_A001.
- **Back-to-back requests:** hold req_valid high with alternating write/read to 0x2020. Required response: req_ready pulses once per transaction, spacing is exactly 7 or 7+RD_SKEW cycles, and there is never a cycle with both ends driving (no X on AddrData).
- **Offset wrap:** write at 0x20FE. Required response: the target stores at offsets FE, FF, 00, 01; read-back returns the identical 64-bit value.
- **Mid-write reset:** assert resetH during write beat 2. Required response: AddrValid=0 and AddrData='z in the same cycle, no rsp_valid, and req_ready=1 on the first edge after resetH deasserts.
- **Request change after accept:** change req_addr and wr_data on the cycle after acceptance. Required response: the bus carries the originally latched values.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the multiplexed AddrData memory bus.
// Holds the initiator state type, bus geometry constants and the debug
// snapshot struct that the initiator exports for observation.
package mem_bus_pkg;

    localparam int BEATS      = 4;
    localparam int WORD_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int PAGE_SHIFT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Snapshot of the sequencing state and of the AddrData drive enable.
    typedef struct packed {
        state_t     state;
        logic [2:0] beat;
        logic       drive;
    } dbg_t;

endpackage

// File: rtl/mem_initiator.sv
// mem_initiator: CPU-side bus master for the multiplexed AddrData bus.
// Accepts one 4-word read or write request over a valid/ready handshake,
// runs the address phase and four data beats, and returns read data with a
// one-cycle rsp_valid pulse.
//
// Ports:
//   clk, resetH          clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake (accepted when both are high)
//   req_rw, req_addr     1 = read / 0 = write, full 16-bit bus address
//   wr_data              write words, word k in [16k+15:16k]
//   rsp_valid            one-cycle pulse in the DONE state
//   rd_data              read words, same packing as wr_data
//   busy                 high whenever not IDLE
//   AddrValid, rw        address-phase strobe and latched direction
//   AddrData             bidirectional address/data bus
//   dbg                  state, beat counter and bus drive enable
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE and does not
// depend on req_valid. The request inputs are ignored after that edge.
module mem_initiator
    import mem_bus_pkg::*;
#(
    parameter int RD_SKEW = 1
) (
    input  logic                      clk,
    input  logic                      resetH,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rw,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [BEATS*WORD_W-1:0]   wr_data,
    output logic                      rsp_valid,
    output logic [BEATS*WORD_W-1:0]   rd_data,
    output logic                      busy,
    output logic                      AddrValid,
    output logic                      rw,
    inout  wire  [WORD_W-1:0]         AddrData,
    output dbg_t                      dbg
);

    localparam logic [2:0] WR_LAST = 3'(BEATS - 1);
    localparam logic [2:0] RD_LAST = 3'(RD_SKEW + BEATS - 1);
    localparam logic [2:0] SKEW_B  = 3'(RD_SKEW);

    state_t                    state_q, state_d;
    logic [2:0]                beat_q, beat_d;
    logic                      rw_q;
    logic [BEATS*WORD_W-1:0]   wdata_q;
    logic [BEATS*WORD_W-1:0]   rd_cap_q;
    logic [BEATS*WORD_W-1:0]   rd_data_q;
    logic                      drive_q, drive_d;
    logic [WORD_W-1:0]         out_q, out_d;

    logic       accept;
    logic       last_beat;
    logic [2:0] rd_idx;

    assign accept    = req_valid && (state_q == IDLE);
    assign last_beat = rw_q ? (beat_q == RD_LAST) : (beat_q == WR_LAST);
    // Read word index for the current beat; beats before the skew wrap to
    // 5..7, so bit 2 clear means "this beat carries a read word".
    assign rd_idx    = beat_q - SKEW_B;

    // Next state plus the registered bus drive: drive_d/out_d describe what
    // the bus must carry in the cycle that state_d/beat_d will represent.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drive_d = 1'b0;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADDR;
                    drive_d = 1'b1;
                    // out_q doubles as the latched address for the ADDR cycle.
                    out_d   = req_addr;
                end
            end
            ADDR: begin
                state_d = XFER;
                beat_d  = 3'd0;
                drive_d = !rw_q;
                out_d   = wdata_q[WORD_W-1:0];
            end
            XFER: begin
                if (last_beat) begin
                    state_d = DONE;
                    beat_d  = 3'd0;
                end else begin
                    beat_d  = beat_q + 3'd1;
                    drive_d = !rw_q;
                    out_d   = wdata_q[{beat_d[1:0], 4'b0000} +: WORD_W];
                end
            end
            DONE: begin
                // Bus turnaround: nobody drives AddrData here.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state_q   <= IDLE;
            beat_q    <= 3'd0;
            rw_q      <= 1'b1;
            wdata_q   <= '0;
            rd_cap_q  <= '0;
            rd_data_q <= '0;
            drive_q   <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drive_q <= drive_d;
            out_q   <= out_d;
            if (accept) begin
                rw_q    <= req_rw;
                wdata_q <= wr_data;
            end
            if (state_q == XFER && rw_q && !rd_idx[2]) begin
                rd_cap_q[{rd_idx[1:0], 4'b0000} +: WORD_W] <= AddrData;
            end
            // The final word arrives on the same edge that publishes the
            // result, so merge it directly instead of going through rd_cap_q.
            if (state_q == XFER && rw_q && last_beat) begin
                rd_data_q <= {AddrData, rd_cap_q[(BEATS-1)*WORD_W-1:0]};
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign AddrValid = (state_q == ADDR);
    assign rsp_valid = (state_q == DONE);
    assign rw        = rw_q;
    assign rd_data   = rd_data_q;
    assign AddrData  = drive_q ? out_q : {WORD_W{1'bz}};

    assign dbg = '{state: state_q, beat: beat_q, drive: drive_q};

endmodule

// File: tb/tb_mem_initiator.sv
`timescale 1ns/1ps
module tb_mem_initiator;
    import mem_bus_pkg::*;

    localparam int RD_SKEW = 1;
    localparam int PERIOD  = 10;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetH = 1'b1;
    always #(PERIOD/2) clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [15:0] req_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsp_valid;
    logic [63:0] rd_data;
    logic        busy;
    logic        AddrValid;
    logic        rw;
    wire  [15:0] AddrData;
    dbg_t        dbg;

    logic        tgt_en = 1'b0;
    logic [15:0] tgt_data = '0;
    assign AddrData = tgt_en ? tgt_data : 16'bz;

    mem_initiator #(.RD_SKEW(RD_SKEW)) dut (
        .clk(clk), .resetH(resetH),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rd_data(rd_data), .busy(busy),
        .AddrValid(AddrValid), .rw(rw), .AddrData(AddrData), .dbg(dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- page-2 target (the bus device) ----------------
    logic [15:0] tgt_mem [256];
    logic [15:0] t_addr;
    logic        t_rw;
    logic        t_active = 1'b0;
    int          t_cyc;

    always @(negedge clk or posedge resetH) begin
        if (resetH) begin
            t_active = 1'b0;
            tgt_en   = 1'b0;
        end else if (AddrValid) begin
            t_addr = AddrData; t_rw = rw; t_cyc = 0; t_active = 1'b1; tgt_en = 1'b0;
        end else if (t_active) begin
            if (t_cyc == (t_rw ? RD_SKEW + 4 : 4)) begin
                t_active = 1'b0;
                tgt_en   = 1'b0;
            end else begin
                if (t_addr[15:12] == 4'h2) begin
                    if (!t_rw) begin
                        tgt_mem[8'(t_addr[7:0] + t_cyc)] = AddrData;
                    end else if (t_cyc >= RD_SKEW) begin
                        tgt_en   = 1'b1;
                        tgt_data = tgt_mem[8'(t_addr[7:0] + t_cyc - RD_SKEW)];
                    end
                end
                t_cyc++;
            end
        end
    end

    // Both ends must never drive the bus in the same cycle.
    always @(negedge clk) begin
        #2;
        if (tgt_en) chk("bus_contention", dbg.drive, 1'b0);
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [256];
    logic [63:0] last_rd = '0;

    function automatic logic [63:0] ref_read(input logic [15:0] a);
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[16*k +: 16] = ref_mem[8'(a[7:0] + k)];
        return v;
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [63:0] wd);
        for (int k = 0; k < 4; k++) ref_mem[8'(a[7:0] + k)] = wd[16*k +: 16];
    endtask

    // ---------------- driver: one full transaction, checked per cycle ----------------
    task automatic do_txn(input logic t_rw, input logic [15:0] a, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic keep_valid, output time t_acc);
        int n = 0;
        int n_xfer = t_rw ? RD_SKEW + 4 : 4;
        req_valid = 1'b1; req_rw = t_rw; req_addr = a; wr_data = wd;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", req_ready, 1'b1);
        t_acc = $time;
        if (!req_ready) return;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        // Request inputs change right after acceptance; bus must not follow.
        req_valid = keep_valid;
        req_rw    = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        wr_data   = {$urandom, $urandom};
        chk("addr_valid", AddrValid, 1'b1);
        chk("addr_value", AddrData, a);
        chk("addr_rw", rw, t_rw);
        chk("addr_drive", dbg.drive, 1'b1);
        chk("addr_ready", req_ready, 1'b0);
        chk("addr_rsp", rsp_valid, 1'b0);
        for (int c = 0; c < n_xfer; c++) begin
            @(negedge clk);
            chk("xfer_addrvalid", AddrValid, 1'b0);
            chk("xfer_rsp", rsp_valid, 1'b0);
            chk("xfer_busy", busy, 1'b1);
            if (!t_rw) begin
                chk("wr_drive", dbg.drive, 1'b1);
                chk("wr_beat", AddrData, wd[16*c +: 16]);
            end else begin
                chk("rd_tristate", dbg.drive, 1'b0);
            end
        end
        @(negedge clk);
        chk("done_rsp", rsp_valid, 1'b1);
        chk("done_drive", dbg.drive, 1'b0);
        chk("done_addrvalid", AddrValid, 1'b0);
        chk("done_busy", busy, 1'b1);
        chk("done_rd_data", rd_data, exp_rd);
        if (t_rw) last_rd = exp_rd;
        else      ref_write(a, wd);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        time t_acc;
        time acc_t [4];
        logic [63:0] exp;
        logic [15:0] a;
        logic        r;

        #(300*1000);
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        time t_acc;
        time acc_t [4];
        logic [63:0] exp;
        logic [15:0] a;
        logic        r;

        vecs[0] = '{1'b0, 16'h2010, 64'hA004_A003_A002_A001, 64'h0};
        vecs[1] = '{1'b1, 16'h2010, 64'h0, 64'hA004_A003_A002_A001};
        vecs[2] = '{1'b0, 16'h20FE, 64'h1111_2222_3333_4444, 64'hA004_A003_A002_A001};
        vecs[3] = '{1'b1, 16'h20FE, 64'h0, 64'h1111_2222_3333_4444};
        vecs[4] = '{1'b0, 16'h2020, 64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444};
        vecs[5] = '{1'b1, 16'h2020, 64'h0, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[6] = '{1'b1, 16'h2010, 64'h0, 64'hA004_A003_A002_A001};

        for (int i = 0; i < 256; i++) begin
            tgt_mem[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset state
        resetH = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addrvalid", AddrValid, 1'b0);
        chk("rst_rw", rw, 1'b1);
        chk("rst_rsp", rsp_valid, 1'b0);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_drive", dbg.drive, 1'b0);
        resetH = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0, t_acc);
            if (i == 0) for (int k = 0; k < 4; k++)
                chk("tgt_store_10", tgt_mem[8'h10 + k], vecs[0].wdata[16*k +: 16]);
            if (i == 2) begin
                chk("tgt_wrap_FE", tgt_mem[8'hFE], 16'h4444);
                chk("tgt_wrap_FF", tgt_mem[8'hFF], 16'h3333);
                chk("tgt_wrap_00", tgt_mem[8'h00], 16'h2222);
                chk("tgt_wrap_01", tgt_mem[8'h01], 16'h1111);
            end
        end

        // Back-to-back alternating write/read with req_valid held high
        for (int i = 0; i < 4; i++) begin
            r   = 1'(i % 2);
            exp = r ? ref_read(16'h2020) : last_rd;
            do_txn(r, 16'h2020, {$urandom, $urandom}, exp, (i < 3), acc_t[i]);
        end
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", 64'((acc_t[i] - acc_t[i-1]) / PERIOD),
                64'(((i - 1) % 2 == 1) ? 7 + RD_SKEW : 7));

        // Randomized traffic against the reference model, including offset wrap
        for (int i = 0; i < 30; i++) begin
            r   = 1'($urandom_range(0, 1));
            a   = 16'h2000 | ($urandom_range(0, 1) ? 16'($urandom_range(0, 15))
                                                    : 16'($urandom_range(250, 255)));
            exp = r ? ref_read(a) : last_rd;
            do_txn(r, a, {$urandom, $urandom}, exp, 1'b0, t_acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during write beat 2
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h2080; wr_data = 64'h5555_6666_7777_8888;
        while (!req_ready) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_beat2", AddrData, 16'h6666);
        #1 resetH = 1'b1;
        #1;
        chk("abort_addrvalid", AddrValid, 1'b0);
        chk("abort_drive", dbg.drive, 1'b0);
        chk("abort_rsp", rsp_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rd_data", rd_data, 64'h0);
        @(negedge clk);
        resetH = 1'b0;
        last_rd = '0;
        @(posedge clk);
        #1 chk("abort_ready", req_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 1'b0);
        end

        // Recovery read after the abort
        do_txn(1'b1, 16'h2010, 64'h0, ref_read(16'h2010), 1'b0, t_acc);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
